trap_sequencer: RTL and testbench

//   Parametrised successor to the single-cycle exception detector. Detects IF/ID/MEM exceptions and

---
 rtl/trap_sequencer_pkg.sv | 43 ++++
 rtl/trap_sequencer_exc_detect.sv | 97 +++++++++
 rtl/trap_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: exception cause codes, privilege
// encodings, load/store funct3 encodings, sequencer FSM states and the ECALL
// cause helper. Imported by exc_detect and trap_sequencer.
package trap_sequencer_pkg;

   localparam logic [4:0] CAUSE_INST_MISALIGN  = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL        = 5'd2;
   localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
   localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] CAUSE_ECALL_U        = 5'd8;
   localparam logic [4:0] CAUSE_ECALL_S        = 5'd9;
   localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_e;

   // The reserved privilege encoding 2'b10 never occurs; treat it as M.
   function automatic logic [4:0] ecall_cause(input logic [1:0] priv);
      case (priv)
         PRIV_U:  return CAUSE_ECALL_U;
         PRIV_S:  return CAUSE_ECALL_S;
         default: return CAUSE_ECALL_M;
      endcase
   endfunction

endpackage

// File: rtl/trap_sequencer_exc_detect.sv
// exc_detect: purely combinational exception detection for the IF, ID and MEM
// stages plus the oldest-instruction-first priority mux.
// Inputs : stage PCs/valids, decode flags and raw instruction, memory address,
//          PC, funct3 and read/write strobes, current privilege.
// Outputs: det_valid (some exception present), det_cause/det_epc/det_tval of
//          the highest-priority exception.
module exc_detect
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int C_EXT = 0
) (
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [31:0]     id_instruction,
   input  logic            id_valid,
   input  logic            id_illegal_inst,
   input  logic            id_ecall,
   input  logic            id_ebreak,
   input  logic            id_mret,
   input  logic            id_sret,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_pc,
   input  logic [2:0]      mem_funct3,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_valid,
   input  logic [1:0]      cur_priv,
   output logic            det_valid,
   output logic [4:0]      det_cause,
   output logic [XLEN-1:0] det_epc,
   output logic [XLEN-1:0] det_tval
);

   logic load_mis;
   logic store_mis;
   logic id_ill;
   logic id_brk;
   logic id_ecl;
   logic if_mis;

   // Doubleword accesses and LWU only exist on RV64; on RV32 those encodings
   // never reach MEM as legal instructions, so they are not checked.
   function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a,
                                       input logic is_load);
      case (f3)
         F3_H:    return a[0];
         F3_HU:   return is_load && a[0];
         F3_W:    return a[1:0] != 2'b00;
         F3_WU:   return is_load && (XLEN == 64) && (a[1:0] != 2'b00);
         F3_D:    return (XLEN == 64) && (a[2:0] != 3'b000);
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      load_mis  = mem_valid && mem_read  && misaligned(mem_funct3, mem_addr[2:0], 1'b1);
      store_mis = mem_valid && mem_write && misaligned(mem_funct3, mem_addr[2:0], 1'b0);
      // xRET from below its privilege level is an illegal instruction.
      id_ill    = id_valid && (id_illegal_inst ||
                               (id_mret && (cur_priv != PRIV_M)) ||
                               (id_sret && (cur_priv == PRIV_U)));
      id_brk    = id_valid && id_ebreak;
      id_ecl    = id_valid && id_ecall;
      if_mis    = if_valid && ((C_EXT != 0) ? if_pc[0] : (if_pc[1:0] != 2'b00));

      det_valid = 1'b1;
      det_cause = CAUSE_INST_MISALIGN;
      det_epc   = if_pc;
      det_tval  = if_pc;
      if (load_mis) begin
         det_cause = CAUSE_LOAD_MISALIGN;
         det_epc   = mem_pc;
         det_tval  = mem_addr;
      end else if (store_mis) begin
         det_cause = CAUSE_STORE_MISALIGN;
         det_epc   = mem_pc;
         det_tval  = mem_addr;
      end else if (id_ill) begin
         det_cause = CAUSE_ILLEGAL;
         det_epc   = id_pc;
         det_tval  = XLEN'(id_instruction);
      end else if (id_brk) begin
         det_cause = CAUSE_BREAKPOINT;
         det_epc   = id_pc;
         det_tval  = id_pc;
      end else if (id_ecl) begin
         det_cause = ecall_cause(cur_priv);
         det_epc   = id_pc;
         det_tval  = '0;
      end else if (!if_mis) begin
         det_valid = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: takes the prioritised exception from exc_detect, resolves
// M/S delegation, latches cause/epc/tval/target and runs the
// FLUSH -> COMMIT (wait csr_ack, with timeout) -> REDIRECT handshake.
// Inputs : pipeline stage info (see exc_detect), cur_priv, medeleg, mtvec,
//          stvec, csr_ack, clk, reset (synchronous, active-high).
// Outputs: trap_flush / redirect_valid pulses, trap_busy, trap_valid level
//          request, latched trap_cause/epc/tval/to_s, redirect_pc, sticky
//          trap_error.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int C_EXT       = 0,
   parameter int SUPPORT_S   = 1,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [31:0]     id_instruction,
   input  logic            id_valid,
   input  logic            id_illegal_inst,
   input  logic            id_ecall,
   input  logic            id_ebreak,
   input  logic            id_mret,
   input  logic            id_sret,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_pc,
   input  logic [2:0]      mem_funct3,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_valid,
   input  logic [1:0]      cur_priv,
   input  logic [XLEN-1:0] medeleg,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] stvec,
   input  logic            csr_ack,
   output logic            trap_flush,
   output logic            trap_busy,
   output logic            trap_valid,
   output logic [4:0]      trap_cause,
   output logic [XLEN-1:0] trap_epc,
   output logic [XLEN-1:0] trap_tval,
   output logic            trap_to_s,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_error
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic            det_valid;
   logic [4:0]      det_cause;
   logic [XLEN-1:0] det_epc;
   logic [XLEN-1:0] det_tval;
   logic            deleg_bit;
   logic            det_to_s;
   logic            tvec_unused;

   trap_state_e     state_q,  state_d;
   logic [4:0]      cause_q,  cause_d;
   logic [XLEN-1:0] epc_q,    epc_d;
   logic [XLEN-1:0] tval_q,   tval_d;
   logic            to_s_q,   to_s_d;
   logic [XLEN-1:0] target_q, target_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic            error_q,  error_d;

   exc_detect #(
      .XLEN  (XLEN),
      .C_EXT (C_EXT)
   ) u_exc_detect (
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .id_pc           (id_pc),
      .id_instruction  (id_instruction),
      .id_valid        (id_valid),
      .id_illegal_inst (id_illegal_inst),
      .id_ecall        (id_ecall),
      .id_ebreak       (id_ebreak),
      .id_mret         (id_mret),
      .id_sret         (id_sret),
      .mem_addr        (mem_addr),
      .mem_pc          (mem_pc),
      .mem_funct3      (mem_funct3),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_valid       (mem_valid),
      .cur_priv        (cur_priv),
      .det_valid       (det_valid),
      .det_cause       (det_cause),
      .det_epc         (det_epc),
      .det_tval        (det_tval)
   );

   // Vector mode bits are not supported; handlers are always direct.
   assign tvec_unused = ^{mtvec[1:0], stvec[1:0]};

   always_comb begin
      deleg_bit = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (int'(det_cause) == i) deleg_bit = medeleg[i];
      end
      // Traps taken in M mode are never delegated downwards.
      det_to_s = (SUPPORT_S != 0) && (cur_priv != PRIV_M) && deleg_bit;
   end

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      tval_d   = tval_q;
      to_s_d   = to_s_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      error_d  = error_q;
      case (state_q)
         ST_IDLE: begin
            if (det_valid) begin
               state_d  = ST_FLUSH;
               cause_d  = det_cause;
               epc_d    = det_epc;
               tval_d   = det_tval;
               to_s_d   = det_to_s;
               target_d = det_to_s ? {stvec[XLEN-1:2], 2'b00} : {mtvec[XLEN-1:2], 2'b00};
            end
         end
         ST_FLUSH: begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
         end
         ST_COMMIT: begin
            if (csr_ack) begin
               state_d = ST_REDIRECT;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               // Give up on csr_file but still redirect so the core is not wedged.
               state_d = ST_REDIRECT;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REDIRECT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cause_q  <= '0;
         epc_q    <= '0;
         tval_q   <= '0;
         to_s_q   <= 1'b0;
         target_q <= '0;
         cnt_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
         tval_q   <= tval_d;
         to_s_q   <= to_s_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         error_q  <= error_d;
      end
   end

   assign trap_flush     = (state_q == ST_FLUSH);
   assign trap_busy      = (state_q != ST_IDLE);
   assign trap_valid     = (state_q == ST_COMMIT);
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign trap_cause     = cause_q;
   assign trap_epc       = epc_q;
   assign trap_tval      = tval_q;
   assign trap_to_s      = to_s_q;
   assign redirect_pc    = target_q;
   assign trap_error     = error_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a table of single-trap vectors applied
// through the full flush/commit/redirect handshake, then hand-written
// sequences for ack timeout, busy-time detections and reset during COMMIT.
// Two instances share stimulus: C_EXT=0 (u_dut0) and C_EXT=1 (u_dut1).
module tb_trap_sequencer;

   localparam logic [31:0] MTV = 32'h0000_4003;
   localparam logic [31:0] STV = 32'h8000_0101;
   localparam logic [31:0] RM  = 32'h0000_4000;
   localparam logic [31:0] RS  = 32'h8000_0100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] if_pc, id_pc, id_instruction, mem_addr, mem_pc, medeleg, mtvec, stvec;
   logic        if_valid, id_valid, id_illegal_inst, id_ecall, id_ebreak, id_mret, id_sret;
   logic [2:0]  mem_funct3;
   logic        mem_read, mem_write, mem_valid, csr_ack;
   logic [1:0]  cur_priv;

   logic        o0_flush, o0_busy, o0_valid, o0_to_s, o0_rvalid, o0_err;
   logic [4:0]  o0_cause;
   logic [31:0] o0_epc, o0_tval, o0_rpc;
   logic        o1_flush, o1_busy, o1_valid, o1_to_s, o1_rvalid, o1_err;
   logic [4:0]  o1_cause;
   logic [31:0] o1_epc, o1_tval, o1_rpc;

   logic        sel;
   logic        s_flush, s_busy, s_valid, s_to_s, s_rvalid, s_err;
   logic [4:0]  s_cause;
   logic [31:0] s_epc, s_tval, s_rpc;

   assign s_flush  = sel ? o1_flush  : o0_flush;
   assign s_busy   = sel ? o1_busy   : o0_busy;
   assign s_valid  = sel ? o1_valid  : o0_valid;
   assign s_to_s   = sel ? o1_to_s   : o0_to_s;
   assign s_rvalid = sel ? o1_rvalid : o0_rvalid;
   assign s_err    = sel ? o1_err    : o0_err;
   assign s_cause  = sel ? o1_cause  : o0_cause;
   assign s_epc    = sel ? o1_epc    : o0_epc;
   assign s_tval   = sel ? o1_tval   : o0_tval;
   assign s_rpc    = sel ? o1_rpc    : o0_rpc;

   trap_sequencer #(.XLEN(32), .C_EXT(0), .SUPPORT_S(1), .ACK_TIMEOUT(15)) u_dut0 (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_valid(if_valid), .id_pc(id_pc),
      .id_instruction(id_instruction), .id_valid(id_valid), .id_illegal_inst(id_illegal_inst),
      .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret), .id_sret(id_sret),
      .mem_addr(mem_addr), .mem_pc(mem_pc), .mem_funct3(mem_funct3), .mem_read(mem_read),
      .mem_write(mem_write), .mem_valid(mem_valid), .cur_priv(cur_priv), .medeleg(medeleg),
      .mtvec(mtvec), .stvec(stvec), .csr_ack(csr_ack), .trap_flush(o0_flush),
      .trap_busy(o0_busy), .trap_valid(o0_valid), .trap_cause(o0_cause), .trap_epc(o0_epc),
      .trap_tval(o0_tval), .trap_to_s(o0_to_s), .redirect_valid(o0_rvalid),
      .redirect_pc(o0_rpc), .trap_error(o0_err)
   );

   trap_sequencer #(.XLEN(32), .C_EXT(1), .SUPPORT_S(1), .ACK_TIMEOUT(15)) u_dut1 (
      .clk(clk), .reset(reset), .if_pc(if_pc), .if_valid(if_valid), .id_pc(id_pc),
      .id_instruction(id_instruction), .id_valid(id_valid), .id_illegal_inst(id_illegal_inst),
      .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret), .id_sret(id_sret),
      .mem_addr(mem_addr), .mem_pc(mem_pc), .mem_funct3(mem_funct3), .mem_read(mem_read),
      .mem_write(mem_write), .mem_valid(mem_valid), .cur_priv(cur_priv), .medeleg(medeleg),
      .mtvec(mtvec), .stvec(stvec), .csr_ack(csr_ack), .trap_flush(o1_flush),
      .trap_busy(o1_busy), .trap_valid(o1_valid), .trap_cause(o1_cause), .trap_epc(o1_epc),
      .trap_tval(o1_tval), .trap_to_s(o1_to_s), .redirect_valid(o1_rvalid),
      .redirect_pc(o1_rpc), .trap_error(o1_err)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  priv;
      logic [31:0] medeleg;
      logic        if_valid;
      logic [31:0] if_pc;
      logic        id_valid;
      logic [31:0] id_pc;
      logic [31:0] inst;
      logic        ill, ecall, ebreak, mret, sret;
      logic        mem_valid, rd, wr;
      logic [2:0]  f3;
      logic [31:0] maddr, mpc;
      logic        exp_trap;
      logic [4:0]  cause;
      logic [31:0] epc, tval;
      logic        to_s;
      logic [31:0] rpc;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t base();
      vec_t v;
      v = '{default: '0};
      v.priv = 2'b11;
      return v;
   endfunction

   task automatic clear_strobes();
      if_valid = 0; id_valid = 0; id_illegal_inst = 0; id_ecall = 0; id_ebreak = 0;
      id_mret = 0; id_sret = 0; mem_read = 0; mem_write = 0; mem_valid = 0;
      if_pc = '0; id_pc = '0; id_instruction = '0; mem_addr = '0; mem_pc = '0;
      mem_funct3 = '0;
   endtask

   task automatic drive(input vec_t v);
      cur_priv = v.priv; medeleg = v.medeleg;
      if_valid = v.if_valid; if_pc = v.if_pc;
      id_valid = v.id_valid; id_pc = v.id_pc; id_instruction = v.inst;
      id_illegal_inst = v.ill; id_ecall = v.ecall; id_ebreak = v.ebreak;
      id_mret = v.mret; id_sret = v.sret;
      mem_valid = v.mem_valid; mem_read = v.rd; mem_write = v.wr;
      mem_funct3 = v.f3; mem_addr = v.maddr; mem_pc = v.mpc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every vector runs the same four cycles so both instances stay in step.
   task automatic run_vec(input int i, input vec_t v);
      sel = v.sel;
      drive(v);
      step();
      clear_strobes();
      if (v.exp_trap) begin
         chk($sformatf("v%0d.flush", i), 32'(s_flush), 32'd1);
         chk($sformatf("v%0d.cause", i), 32'(s_cause), 32'(v.cause));
         chk($sformatf("v%0d.epc", i), s_epc, v.epc);
         chk($sformatf("v%0d.tval", i), s_tval, v.tval);
         chk($sformatf("v%0d.to_s", i), 32'(s_to_s), 32'(v.to_s));
      end else begin
         chk($sformatf("v%0d.busy", i), 32'(s_busy), 32'd0);
      end
      step();
      if (v.exp_trap) chk($sformatf("v%0d.trap_valid", i), 32'(s_valid), 32'd1);
      csr_ack = 1;
      step();
      csr_ack = 0;
      if (v.exp_trap) begin
         chk($sformatf("v%0d.redirect_valid", i), 32'(s_rvalid), 32'd1);
         chk($sformatf("v%0d.redirect_pc", i), s_rpc, v.rpc);
      end
      step();
      chk($sformatf("v%0d.idle", i), 32'(s_busy), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   n;
      sel = 0; csr_ack = 0; reset = 1; cur_priv = 2'b11; medeleg = '0;
      mtvec = MTV; stvec = STV;
      clear_strobes();

      // LW misaligned in M
      v = base(); v.mem_valid = 1; v.rd = 1; v.f3 = 3'b010; v.maddr = 32'h1002; v.mpc = 32'h200;
      v.exp_trap = 1; v.cause = 4; v.epc = 32'h200; v.tval = 32'h1002; v.rpc = RM; tbl.push_back(v);
      // ECALL from U, delegated
      v = base(); v.priv = 2'b00; v.medeleg = 32'h100; v.id_valid = 1; v.ecall = 1; v.id_pc = 32'h300;
      v.exp_trap = 1; v.cause = 8; v.epc = 32'h300; v.tval = 0; v.to_s = 1; v.rpc = RS; tbl.push_back(v);
      // illegal + SW misaligned: store wins
      v = base(); v.id_valid = 1; v.ill = 1; v.inst = 32'hFFFF_FFFF; v.id_pc = 32'h304;
      v.mem_valid = 1; v.wr = 1; v.f3 = 3'b010; v.maddr = 32'h3; v.mpc = 32'h2F8;
      v.exp_trap = 1; v.cause = 6; v.epc = 32'h2F8; v.tval = 32'h3; v.rpc = RM; tbl.push_back(v);
      // fetch 0x102: C_EXT=0 traps
      v = base(); v.if_valid = 1; v.if_pc = 32'h102;
      v.exp_trap = 1; v.cause = 0; v.epc = 32'h102; v.tval = 32'h102; v.rpc = RM; tbl.push_back(v);
      // fetch 0x102: C_EXT=1 no trap
      v = base(); v.sel = 1; v.if_valid = 1; v.if_pc = 32'h102; tbl.push_back(v);
      // fetch 0x101: C_EXT=1 traps
      v = base(); v.sel = 1; v.if_valid = 1; v.if_pc = 32'h101;
      v.exp_trap = 1; v.cause = 0; v.epc = 32'h101; v.tval = 32'h101; v.rpc = RM; tbl.push_back(v);
      // LH odd address
      v = base(); v.mem_valid = 1; v.rd = 1; v.f3 = 3'b001; v.maddr = 32'h11; v.mpc = 32'h210;
      v.exp_trap = 1; v.cause = 4; v.epc = 32'h210; v.tval = 32'h11; v.rpc = RM; tbl.push_back(v);
      // LB never misaligned
      v = base(); v.mem_valid = 1; v.rd = 1; v.f3 = 3'b000; v.maddr = 32'h13; tbl.push_back(v);
      // SH odd address
      v = base(); v.mem_valid = 1; v.wr = 1; v.f3 = 3'b001; v.maddr = 32'h5; v.mpc = 32'h220;
      v.exp_trap = 1; v.cause = 6; v.epc = 32'h220; v.tval = 32'h5; v.rpc = RM; tbl.push_back(v);
      // LW misaligned but mem_valid low
      v = base(); v.rd = 1; v.f3 = 3'b010; v.maddr = 32'h3; tbl.push_back(v);
      // EBREAK + ECALL from S, ebreak delegated
      v = base(); v.priv = 2'b01; v.medeleg = 32'h8; v.id_valid = 1; v.ebreak = 1; v.ecall = 1;
      v.id_pc = 32'h400; v.exp_trap = 1; v.cause = 3; v.epc = 32'h400; v.tval = 32'h400;
      v.to_s = 1; v.rpc = RS; tbl.push_back(v);
      // MRET from S -> illegal
      v = base(); v.priv = 2'b01; v.id_valid = 1; v.mret = 1; v.inst = 32'h3020_0073; v.id_pc = 32'h410;
      v.exp_trap = 1; v.cause = 2; v.epc = 32'h410; v.tval = 32'h3020_0073; v.rpc = RM; tbl.push_back(v);
      // MRET from M is fine
      v = base(); v.id_valid = 1; v.mret = 1; v.inst = 32'h3020_0073; tbl.push_back(v);
      // SRET from U -> illegal, delegated
      v = base(); v.priv = 2'b00; v.medeleg = 32'h4; v.id_valid = 1; v.sret = 1;
      v.inst = 32'h1020_0073; v.id_pc = 32'h420; v.exp_trap = 1; v.cause = 2; v.epc = 32'h420;
      v.tval = 32'h1020_0073; v.to_s = 1; v.rpc = RS; tbl.push_back(v);
      // ECALL from M never delegated
      v = base(); v.medeleg = 32'hFFFF_FFFF; v.id_valid = 1; v.ecall = 1; v.id_pc = 32'h430;
      v.exp_trap = 1; v.cause = 11; v.epc = 32'h430; v.rpc = RM; tbl.push_back(v);
      // ECALL from S, not delegated
      v = base(); v.priv = 2'b01; v.id_valid = 1; v.ecall = 1; v.id_pc = 32'h440;
      v.exp_trap = 1; v.cause = 9; v.epc = 32'h440; v.rpc = RM; tbl.push_back(v);
      // EBREAK beats misaligned fetch
      v = base(); v.id_valid = 1; v.ebreak = 1; v.id_pc = 32'h450; v.if_valid = 1; v.if_pc = 32'h2;
      v.exp_trap = 1; v.cause = 3; v.epc = 32'h450; v.tval = 32'h450; v.rpc = RM; tbl.push_back(v);

      // reset state
      step();
      step();
      chk("rst.busy", 32'(s_busy), 32'd0);
      chk("rst.flush", 32'(s_flush), 32'd0);
      chk("rst.valid", 32'(s_valid), 32'd0);
      chk("rst.rpc", s_rpc, 32'd0);
      chk("rst.err", 32'(s_err), 32'd0);
      reset = 0;
      step();

      foreach (tbl[i]) run_vec(i, tbl[i]);

      // ack timeout; detections during busy ignored; sticky error
      sel = 0;
      v = base(); v.mem_valid = 1; v.rd = 1; v.f3 = 3'b010; v.maddr = 32'h1002; v.mpc = 32'h500;
      drive(v);
      step();
      clear_strobes();
      chk("to.flush", 32'(s_flush), 32'd1);
      n = 0;
      step();
      while (s_valid && n < 40) begin
         n++;
         if (n == 14) chk("to.err_early", 32'(s_err), 32'd0);
         if (n == 5) begin
            id_valid = 1; id_ebreak = 1; id_pc = 32'h600;
         end
         step();
      end
      chk("to.commit_cycles", 32'(n), 32'd15);
      chk("to.redirect_valid", 32'(s_rvalid), 32'd1);
      chk("to.err", 32'(s_err), 32'd1);
      chk("to.cause_stable", 32'(s_cause), 32'd4);
      chk("to.redirect_pc", s_rpc, RM);
      step();
      chk("to.idle", 32'(s_busy), 32'd0);
      step();
      clear_strobes();
      chk("to.next_flush", 32'(s_flush), 32'd1);
      chk("to.next_cause", 32'(s_cause), 32'd3);
      chk("to.next_epc", s_epc, 32'h600);
      step();
      csr_ack = 1;
      step();
      csr_ack = 0;
      chk("to.next_redirect", 32'(s_rvalid), 32'd1);
      step();
      chk("to.err_sticky", 32'(s_err), 32'd1);

      // reset during COMMIT with ack pending
      drive(v);
      step();
      clear_strobes();
      step();
      chk("rc.commit", 32'(s_valid), 32'd1);
      reset = 1; csr_ack = 1;
      step();
      chk("rc.busy", 32'(s_busy), 32'd0);
      chk("rc.valid", 32'(s_valid), 32'd0);
      chk("rc.rvalid", 32'(s_rvalid), 32'd0);
      chk("rc.cause", 32'(s_cause), 32'd0);
      chk("rc.epc", s_epc, 32'd0);
      chk("rc.tval", s_tval, 32'd0);
      chk("rc.rpc", s_rpc, 32'd0);
      chk("rc.err", 32'(s_err), 32'd0);
      reset = 0; csr_ack = 0;
      step();
      chk("rc.idle", 32'(s_busy), 32'd0);
      id_valid = 1; id_ebreak = 1; id_pc = 32'h700; cur_priv = 2'b11;
      step();
      clear_strobes();
      chk("rc.flush", 32'(s_flush), 32'd1);
      chk("rc.eb_cause", 32'(s_cause), 32'd3);
      csr_ack = 1;
      step();
      csr_ack = 0;
      chk("rc.eb_valid", 32'(s_valid), 32'd1);
      step();
      chk("rc.ack_in_flush_ignored", 32'(s_valid), 32'd1);
      chk("rc.no_early_redirect", 32'(s_rvalid), 32'd0);
      csr_ack = 1;
      step();
      csr_ack = 0;
      chk("rc.eb_redirect", 32'(s_rvalid), 32'd1);
      chk("rc.eb_rpc", s_rpc, RM);
      step();
      chk("rc.eb_idle", 32'(s_busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
